// File: rtl/gearbox_rx_if.sv
// Lane-side bundle for the 64b/66b receive gearbox: the incoming lane word
// and slip request, plus the recovered block coming back out.
interface gearbox_rx_if #(
    parameter int BLOCK_DATA_W = 64,
    parameter int HEAD_W       = 2,
    parameter int DATA_W       = 64
);
    logic [DATA_W-1:0]       data_i;
    logic                    slip_i;
    logic                    valid_o;
    logic [HEAD_W-1:0]       head_o;
    logic [BLOCK_DATA_W-1:0] data_o;

    // The lane source drives words and slips and watches recovered blocks.
    modport master (
        output data_i,
        output slip_i,
        input  valid_o,
        input  head_o,
        input  data_o
    );

    // The gearbox consumes words and slips and produces blocks.
    modport slave (
        input  data_i,
        input  slip_i,
        output valid_o,
        output head_o,
        output data_o
    );
endinterface

// File: rtl/gearbox_rx.sv
// Receive gearbox: turns a continuous stream of DATA_W-bit lane words into
// (HEAD_W + BLOCK_DATA_W)-bit blocks. Leftover bits wait in a residue buffer
// (oldest bit at bit 0) until a full block is available. A slip request
// throws away the single oldest pending bit so a block aligner can walk the
// block boundary one bit at a time.
module gearbox_rx #(
    parameter int BLOCK_DATA_W = 64,
    parameter int HEAD_W       = 2,
    parameter int DATA_W       = 64
) (
    input  logic         clk,
    input  logic         nreset,
    gearbox_rx_if.slave  bus
);
    localparam int BLK_W  = BLOCK_DATA_W + HEAD_W;
    localparam int CAND_W = BLK_W + DATA_W;
    localparam int CNT_W  = $clog2(CAND_W + 1);

    localparam logic [CNT_W-1:0] BLK_LEN  = CNT_W'(BLK_W);
    localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [BLK_W-1:0]        resid_q, resid_d;
    logic [CNT_W-1:0]        fill_q, fill_d;
    logic                    valid_q, valid_d;
    logic [HEAD_W-1:0]       head_q, head_d;
    logic [BLOCK_DATA_W-1:0] data_q, data_d;

    logic [BLK_W-1:0]  keepMask;
    logic [CAND_W-1:0] cand;
    logic [CNT_W-1:0]  candLen;

    // Build the candidate stream (new word stacked above the valid residue
    // bits), apply an optional one-bit slip, then either peel off one block
    // or keep everything as residue. Residue bits above fill are masked off
    // so stale contents can never leak into a block.
    always_comb begin
        keepMask = {BLK_W{1'b1}} >> (BLK_LEN - fill_q);
        cand     = (CAND_W'(bus.data_i) << fill_q) | CAND_W'(resid_q & keepMask);
        candLen  = fill_q + WORD_LEN;

        if (bus.slip_i) begin
            cand    = cand >> 1;
            candLen = candLen - ONE;
        end

        resid_d = resid_q;
        fill_d  = fill_q;
        valid_d = 1'b0;
        head_d  = head_q;
        data_d  = data_q;

        if (candLen >= BLK_LEN) begin
            valid_d = 1'b1;
            head_d  = cand[HEAD_W-1:0];
            data_d  = cand[BLK_W-1:HEAD_W];
            resid_d = BLK_W'(cand >> BLK_W);
            fill_d  = candLen - BLK_LEN;
        end else begin
            resid_d = cand[BLK_W-1:0];
            fill_d  = candLen;
        end
    end

    // Fill count and registered block outputs; reset empties the buffer so
    // the first word after reset starts a fresh block at bit 0.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            fill_q  <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
            data_q  <= '0;
        end else begin
            fill_q  <= fill_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            data_q  <= data_d;
        end
    end

    // Residue storage needs no reset: only the lowest fill bits are ever used.
    always_ff @(posedge clk) begin
        resid_q <= resid_d;
    end

    assign bus.valid_o = valid_q;
    assign bus.head_o  = head_q;
    assign bus.data_o  = data_q;

endmodule

// File: tb/tb_gearbox_rx.sv
// Bench for gearbox_rx: a 64-bit-lane instance driven from a directed vector
// table and block-stream sequences, and a 16-bit-lane instance for the
// narrow-lane assembly and hold behaviour.
module tb_gearbox_rx;

    logic clk;
    logic nreset64;
    logic nreset16;

    int testsRun;
    int testsFailed;

    gearbox_rx_if #(.BLOCK_DATA_W(64), .HEAD_W(2), .DATA_W(64)) bus64 ();
    gearbox_rx_if #(.BLOCK_DATA_W(64), .HEAD_W(2), .DATA_W(16)) bus16 ();

    gearbox_rx #(.BLOCK_DATA_W(64), .HEAD_W(2), .DATA_W(64)) dut64 (
        .clk    (clk),
        .nreset (nreset64),
        .bus    (bus64.slave)
    );

    gearbox_rx #(.BLOCK_DATA_W(64), .HEAD_W(2), .DATA_W(16)) dut16 (
        .clk    (clk),
        .nreset (nreset16),
        .bus    (bus16.slave)
    );

    typedef struct {
        logic        nrst;
        logic        slip;
        logic [63:0] data;
        logic        expValid;
        logic [1:0]  expHead;
        logic [63:0] expData;
    } vec_t;

    vec_t        vecs [10];
    logic [63:0] w [8];
    logic [15:0] h [9];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the run ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs to the selected instance, clock it, and
    // settle just after the edge so registered outputs reflect this cycle.
    task automatic applyStimulus(input logic nrst, input logic slip,
                                 input logic [63:0] data, input bit sel16);
        if (sel16) begin
            nreset16     = nrst;
            bus16.slip_i = slip;
            bus16.data_i = data[15:0];
        end else begin
            nreset16     = 1'b0;
            nreset64     = nrst;
            bus64.slip_i = slip;
            bus64.data_i = data;
        end
        @(posedge clk);
        #1;
    endtask

    // Compare a full output triple against the expected block.
    task automatic checkOutput(input string name,
                               input logic actV, input logic [1:0] actH, input logic [63:0] actD,
                               input logic expV, input logic [1:0] expH, input logic [63:0] expD);
        testsRun++;
        if (actV !== expV || actH !== expH || actD !== expD) begin
            testsFailed++;
            $display("[TB] FAIL %s: got valid=%0b head=%b data=%h, required valid=%0b head=%b data=%h",
                     name, actV, actH, actD, expV, expH, expD);
        end
    endtask

    // Compare a single valid flag.
    task automatic checkBit(input string name, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0b, required %0b", name, act, exp);
        end
    endtask

    // Compare an integer count.
    task automatic checkInt(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Generate random blocks with legal headers, serialise them (optionally
    // behind junk bits), feed them to the 64-bit instance with slip held for
    // the first slipCycles words, and check every block produced after the
    // slip window against the transmitted block blkSkip positions ahead.
    task automatic runStream(input string name, input int nBlocks, input int junk,
                             input int slipCycles, input int expBlocks, input int blkSkip,
                             input bit checkGaps);
        logic [65:0] blks [$];
        logic        bits [$];
        logic [65:0] blk;
        logic [65:0] expBlk;
        logic [63:0] word;
        int          nWords;
        int          outIdx;
        for (int b = 0; b < nBlocks; b++) begin
            blk[65:34] = $urandom();
            blk[33:2]  = $urandom();
            blk[1:0]   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            blks.push_back(blk);
        end
        for (int j = 0; j < junk; j++) bits.push_back(1'($urandom_range(0, 1)));
        for (int b = 0; b < nBlocks; b++) begin
            blk = blks[b];
            for (int i = 0; i < 66; i++) bits.push_back(blk[i]);
        end
        nWords = (bits.size() + 63) / 64;
        while (bits.size() < nWords * 64) bits.push_back(1'($urandom_range(0, 1)));

        applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
        outIdx = 0;
        for (int c = 0; c < nWords; c++) begin
            for (int i = 0; i < 64; i++) word[i] = bits[c * 64 + i];
            applyStimulus(1'b1, (c < slipCycles) ? 1'b1 : 1'b0, word, 1'b0);
            if (checkGaps)
                checkBit($sformatf("%s valid w%0d", name, c), bus64.valid_o, (c % 33) != 0);
            if (bus64.valid_o === 1'b1) begin
                if (c >= slipCycles && outIdx + blkSkip < nBlocks) begin
                    expBlk = blks[outIdx + blkSkip];
                    checkOutput($sformatf("%s block%0d", name, outIdx),
                                bus64.valid_o, bus64.head_o, bus64.data_o,
                                1'b1, expBlk[1:0], expBlk[65:2]);
                end
                outIdx++;
            end
        end
        checkInt($sformatf("%s block count", name), outIdx, expBlocks);
    endtask

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        nreset64     = 1'b0;
        nreset16     = 1'b0;
        bus64.slip_i = 1'b0;
        bus64.data_i = '0;
        bus16.slip_i = 1'b0;
        bus16.data_i = '0;

        for (int i = 0; i < 8; i++) w[i] = {$urandom(), $urandom()};
        for (int i = 0; i < 9; i++) h[i] = 16'($urandom());

        // Directed vectors: reset (slip ignored), first block, second block,
        // mid-stream reset, restart, slip on a block-producing cycle.
        vecs[0] = '{1'b0, 1'b1, w[7], 1'b0, 2'b00, 64'h0};
        vecs[1] = '{1'b0, 1'b0, w[7], 1'b0, 2'b00, 64'h0};
        vecs[2] = '{1'b1, 1'b0, w[0], 1'b0, 2'b00, 64'h0};
        vecs[3] = '{1'b1, 1'b0, w[1], 1'b1, w[0][1:0], {w[1][1:0], w[0][63:2]}};
        vecs[4] = '{1'b1, 1'b0, w[2], 1'b1, w[1][3:2], {w[2][3:0], w[1][63:4]}};
        vecs[5] = '{1'b0, 1'b1, w[3], 1'b0, 2'b00, 64'h0};
        vecs[6] = '{1'b1, 1'b0, w[4], 1'b0, 2'b00, 64'h0};
        vecs[7] = '{1'b1, 1'b0, w[5], 1'b1, w[4][1:0], {w[5][1:0], w[4][63:2]}};
        vecs[8] = '{1'b1, 1'b1, w[6], 1'b1, w[5][4:3], {w[6][4:0], w[5][63:5]}};
        vecs[9] = '{1'b1, 1'b0, w[7], 1'b1, w[6][6:5], {w[7][6:0], w[6][63:7]}};

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].nrst, vecs[v].slip, vecs[v].data, 1'b0);
            checkOutput($sformatf("vec%0d", v), bus64.valid_o, bus64.head_o, bus64.data_o,
                        vecs[v].expValid, vecs[v].expHead, vecs[v].expData);
        end

        // Reset pulse after ten words, then restart from fresh words.
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, {$urandom(), $urandom()}, 1'b0);
        applyStimulus(1'b0, 1'b0, w[3], 1'b0);
        checkOutput("midreset outputs", bus64.valid_o, bus64.head_o, bus64.data_o, 1'b0, 2'b00, 64'h0);
        applyStimulus(1'b1, 1'b0, w[2], 1'b0);
        checkOutput("midreset first word", bus64.valid_o, bus64.head_o, bus64.data_o, 1'b0, 2'b00, 64'h0);
        applyStimulus(1'b1, 1'b0, w[3], 1'b0);
        checkOutput("midreset first block", bus64.valid_o, bus64.head_o, bus64.data_o,
                    1'b1, w[2][1:0], {w[3][1:0], w[2][63:2]});

        // 64 blocks in 66 words: gaps only after word 0 and word 33.
        runStream("cadence", 64, 0, 0, 64, 0, 1'b1);

        // One junk bit ahead of the stream, removed by a single slip.
        runStream("align", 32, 1, 1, 32, 0, 1'b0);

        // 66 slips in a row drop exactly one block's worth of bits.
        runStream("slip66", 70, 0, 66, 69, 1, 1'b0);

        // Narrow lane: five words form the first block, then three words
        // of hold before the next block completes.
        applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, {48'h0, h[i]}, 1'b1);
            checkOutput($sformatf("lane16 w%0d", i), bus16.valid_o, bus16.head_o, bus16.data_o,
                        1'b0, 2'b00, 64'h0);
        end
        applyStimulus(1'b1, 1'b0, {48'h0, h[4]}, 1'b1);
        checkOutput("lane16 block0", bus16.valid_o, bus16.head_o, bus16.data_o,
                    1'b1, h[0][1:0], {h[4][1:0], h[3], h[2], h[1], h[0][15:2]});
        for (int i = 5; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, {48'h0, h[i]}, 1'b1);
            checkOutput($sformatf("lane16 hold w%0d", i), bus16.valid_o, bus16.head_o, bus16.data_o,
                        1'b0, h[0][1:0], {h[4][1:0], h[3], h[2], h[1], h[0][15:2]});
        end
        applyStimulus(1'b1, 1'b0, {48'h0, h[8]}, 1'b1);
        checkOutput("lane16 block1", bus16.valid_o, bus16.head_o, bus16.data_o,
                    1'b1, h[4][3:2], {h[8][3:0], h[7], h[6], h[5], h[4][15:4]});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/gearbox_rx.md
GEARBOX_RX -- requirements
Module: gearbox_rx

Interface
REQ-001 SHALL have parameter BLOCK_DATA_W, default 64, payload bits per block.
REQ-002 SHALL have parameter HEAD_W, default 2, sync header bits per block.
REQ-003 SHALL have parameter DATA_W, default 64, lane word width; supported values 16, 32, 64.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port nreset  input  1  reset, synchronous and active-low.
REQ-006 SHALL have port data_i  input  DATA_W  lane word, valid every cycle, bit 0 received first.
REQ-007 SHALL have port slip_i  input  1  one-cycle request to discard one received bit, used for block alignment.
REQ-008 SHALL have port valid_o  output  1  head_o and data_o hold a complete block this cycle.
REQ-009 SHALL have port head_o  output  HEAD_W  sync header of the block (block bits [HEAD_W-1:0]).
REQ-010 SHALL have port data_o  output  BLOCK_DATA_W  block payload (block bits [BLOCK_DATA_W+HEAD_W-1:HEAD_W]).

Function
REQ-011 SHALL keep a residue buffer of BLOCK_DATA_W+HEAD_W bits (66 by default), oldest bit at bit 0, plus a fill counter of at least 7 bits, range 0..65.
REQ-012 SHALL each cycle form the candidate stream {data_i, buffer[fill-1:0]}: data_i bit 0 sits directly above the oldest stored bits; candidate length is fill+DATA_W.
REQ-013 SHALL, when slip_i=1, drop the single oldest candidate bit (buffer bit 0, or data_i bit 0 when fill=0) before extraction; candidate length is then fill+DATA_W-1.
REQ-014 SHALL, when candidate length >= 66, extract the lowest 66 candidate bits as the block, register valid_o=1 with head_o/data_o from that block, and store the remaining bits as the new residue.
REQ-015 SHALL, when candidate length < 66, register valid_o=0, store all candidate bits, and hold head_o/data_o at their previous values.
REQ-016 SHALL register outputs; a block is presented the cycle after the clock edge that sampled its last bit (latency 1 cycle).
REQ-017 SHALL, for DATA_W=64 and no slips, produce exactly 32 valid blocks per 33 input words, periodic.
REQ-018 SHALL, for DATA_W=32/16, produce exactly 32 valid blocks per 66/132 input words, no slips.
REQ-019 SHALL never let fill exceed 65 and never lose or duplicate a bit other than the one slipped bit.
REQ-020 SHALL accept slip_i on any cycle, including back-to-back cycles (one bit dropped per asserted cycle) and cycles that output a block.
REQ-021 SHALL ignore buffer contents above fill; unused bits are don't-care but SHALL NOT reach head_o/data_o.

Reset
REQ-022 SHALL, on clk edge with nreset=0, set fill=0, valid_o=0, head_o=0, data_o=0; buffer contents don't-care.
REQ-023 SHALL, with nreset=0 mid-stream, discard all residue; the first data_i sampled with nreset=1 becomes block bit 0.
REQ-024 SHALL ignore slip_i and data_i in any cycle with nreset=0.

Verification
REQ-025 SHALL cover DATA_W=64: reset, then words W0,W1 -> valid_o=1 one cycle after W1 sampled, head_o=W0[1:0], data_o={W1[1:0],W0[63:2]}.
REQ-026 SHALL cover 33 consecutive words after reset, DATA_W=64 -> exactly 32 valid_o pulses; valid_o=0 only in the cycle after W0 and the cycle after W33 (the second gap pattern repeats every 33).
REQ-027 SHALL cover a known 66-bit block stream prefixed by 1 junk bit, slip_i=1 for one cycle -> all subsequent blocks match the transmitted blocks exactly (headers 2'b01/2'b10).
REQ-028 SHALL cover nreset=0 for one cycle after 10 words -> next cycle valid_o=0, head_o=0, data_o=0; first new block equals the first two post-reset words as in REQ-025.
REQ-029 SHALL cover DATA_W=16: 5 words after reset -> first valid_o one cycle after word 5, block = {word4[1:0],word3,word2,word1,word0} split as REQ-009/REQ-010.
REQ-030 SHALL cover slip_i held high 66 consecutive cycles, DATA_W=64 -> exactly one full block (66 bits) dropped relative to no-slip output, no corruption of later blocks.
